// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: sequencer states, status codes, frame layout
// constants, keyboard command bytes and the parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RELEASE   = 3'd2,
        SHIFT     = 3'd3,
        WAIT_IDLE = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6
    } tx_state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_NOACK   = 2'd1,
        ERR_TIMEOUT = 2'd2
    } tx_err_t;

    // Frame layout: start, 8 data bits LSB first, odd parity, stop, device ACK.
    localparam int DATA_BITS = 8;
    localparam int ACK_EDGE  = 11;

    // Keyboard command bytes.
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // Odd parity bit: makes the total count of ones over data + parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between the game FSM and the PS/2 transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic [1:0] tx_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  tx_done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output tx_done,
        output tx_err
    );

endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: two-flop synchronizer, run-length deglitch filter
// and a one-cycle falling-edge pulse on the filtered level. The filtered
// level only moves after FILTER_LEN consecutive samples disagree with it,
// so a pin edge shows up on fall 2 + FILTER_LEN cycles later.
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

    logic             meta_r;
    logic             sync_r;
    logic             level_r;
    logic             fall_r;
    logic [RUN_W-1:0] run_r;

    // Bring the raw pin into the clock domain; idle bus level is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= pin;
            sync_r <= meta_r;
        end
    end

    // Accept a new level only after a full run of disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= 1'b1;
            fall_r  <= 1'b0;
            run_r   <= {RUN_W{1'b0}};
        end else if (sync_r == level_r) begin
            fall_r  <= 1'b0;
            run_r   <= {RUN_W{1'b0}};
        end else if (run_r == RUN_LAST) begin
            level_r <= sync_r;
            fall_r  <= ~sync_r;
            run_r   <= {RUN_W{1'b0}};
        end else begin
            fall_r  <= 1'b0;
            run_r   <= run_r + RUN_W'(1);
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts a command byte out on device clock falls, checks the device ACK and
// reports a one-cycle status pulse. All pin enables are registered.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int PACKET_TIMEOUT = 200000,
    parameter int FILTER_LEN     = 4
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int MAX_ST  = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
    localparam int MAX_ALL = (MAX_ST > INHIBIT_CYCLES) ? MAX_ST : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_START  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PACKET_TIMEOUT - 1);
    localparam logic [3:0]       EDGE_DATA  = 4'(DATA_BITS);
    localparam logic [3:0]       EDGE_STOP  = 4'(DATA_BITS + 1);
    localparam logic [3:0]       EDGE_ACK   = 4'(ACK_EDGE - 1);

    tx_state_t        state_r;
    tx_err_t          err_r;
    logic [7:0]       data_r;
    logic             parity_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] pkt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] pkt_inc_s;
    logic [3:0]       edge_r;
    logic             tx_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             clk_oe_r;
    logic             data_oe_r;
    logic             dmeta_r;
    logic             dsync_r;
    logic             clk_level_s;
    logic             clk_fall_s;

    // Deglitched device clock with falling-edge pulse.
    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2_clk_in),
        .level (clk_level_s),
        .fall  (clk_fall_s)
    );

    // Two-flop synchronizer for the data pin; only the ACK and idle checks read it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmeta_r <= 1'b1;
            dsync_r <= 1'b1;
        end else begin
            dmeta_r <= ps2_data_in;
            dsync_r <= dmeta_r;
        end
    end

    // Saturating next values for the phase timer and the packet timer.
    always_comb begin
        cnt_inc_s = cnt_r;
        pkt_inc_s = pkt_r;
        if (cnt_r != CNT_MAX) begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_inc_s = cnt_r;
        end
        if (pkt_r != CNT_MAX) begin
            pkt_inc_s = pkt_r + CNT_W'(1);
        end else begin
            pkt_inc_s = pkt_r;
        end
    end

    // Transfer sequencer: request-to-send, bit shifting, ACK check and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            err_r      <= ERR_OK;
            data_r     <= 8'h00;
            parity_r   <= 1'b0;
            cnt_r      <= CNT_ZERO;
            pkt_r      <= CNT_ZERO;
            edge_r     <= 4'd0;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= 1'b0;
                    err_r     <= ERR_OK;
                    data_oe_r <= 1'b0;
                    if (tx.tx_valid) begin
                        data_r     <= tx.tx_data;
                        parity_r   <= odd_parity(tx.tx_data);
                        cnt_r      <= CNT_ZERO;
                        edge_r     <= 4'd0;
                        tx_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        clk_oe_r   <= 1'b1;
                        state_r    <= INHIBIT;
                    end else begin
                        tx_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        clk_oe_r   <= 1'b0;
                    end
                end
                INHIBIT: begin
                    // Clock held low throughout; data joins it on the last cycle as the start bit.
                    cnt_r <= cnt_inc_s;
                    if (cnt_r == INH_LAST) begin
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b1;
                        cnt_r     <= CNT_ZERO;
                        state_r   <= RELEASE;
                    end else if (cnt_r == INH_START) begin
                        clk_oe_r  <= 1'b1;
                        data_oe_r <= 1'b1;
                    end else begin
                        clk_oe_r  <= 1'b1;
                        data_oe_r <= 1'b0;
                    end
                end
                RELEASE: begin
                    clk_oe_r <= 1'b0;
                    if (clk_fall_s) begin
                        edge_r    <= 4'd1;
                        pkt_r     <= CNT_ZERO;
                        data_oe_r <= ~data_r[0];
                        state_r   <= SHIFT;
                    end else if (cnt_r == START_LAST) begin
                        done_r    <= 1'b1;
                        err_r     <= ERR_TIMEOUT;
                        data_oe_r <= 1'b0;
                        state_r   <= ERR;
                    end else begin
                        cnt_r     <= cnt_inc_s;
                        data_oe_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    // edge_r holds the number of falls seen so far.
                    pkt_r <= pkt_inc_s;
                    if (pkt_r == PKT_LAST) begin
                        done_r    <= 1'b1;
                        err_r     <= ERR_TIMEOUT;
                        data_oe_r <= 1'b0;
                        state_r   <= ERR;
                    end else if (clk_fall_s) begin
                        edge_r <= edge_r + 4'd1;
                        if (edge_r < EDGE_DATA) begin
                            data_oe_r <= ~data_r[edge_r[2:0]];
                        end else if (edge_r == EDGE_DATA) begin
                            data_oe_r <= ~parity_r;
                        end else if (edge_r == EDGE_STOP) begin
                            data_oe_r <= 1'b0;
                        end else if (edge_r == EDGE_ACK && !dsync_r) begin
                            data_oe_r <= 1'b0;
                            state_r   <= WAIT_IDLE;
                        end else begin
                            done_r    <= 1'b1;
                            err_r     <= ERR_NOACK;
                            data_oe_r <= 1'b0;
                            state_r   <= ERR;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                WAIT_IDLE: begin
                    // Device must release both lines before the packet timer runs out.
                    pkt_r     <= pkt_inc_s;
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    if (pkt_r == PKT_LAST) begin
                        done_r  <= 1'b1;
                        err_r   <= ERR_TIMEOUT;
                        state_r <= ERR;
                    end else if (clk_level_s && dsync_r) begin
                        done_r  <= 1'b1;
                        err_r   <= ERR_OK;
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                DONE, ERR: begin
                    done_r     <= 1'b0;
                    err_r      <= ERR_OK;
                    tx_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    clk_oe_r   <= 1'b0;
                    data_oe_r  <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    done_r     <= 1'b0;
                    err_r      <= ERR_OK;
                    tx_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    clk_oe_r   <= 1'b0;
                    data_oe_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready = tx_ready_r;
    assign tx.busy     = busy_r;
    assign tx.tx_done  = done_r;
    assign tx.tx_err   = err_r;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus model with a scripted keyboard
// that clocks at a 40-cycle period, samples host bits on its rising edges
// and optionally ACKs. Expected frames/status are queued at send time and
// popped when tx_done appears.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int STO = 500;
    localparam int PTO = 200000;
    localparam int FL  = 4;

    typedef struct {
        logic [10:0] bits;
        logic [1:0]  err;
        bit          chk_bits;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic dev_clk = 1'b1;
    logic dev_data_low = 1'b0;
    wire  ps2_clk_pin  = ps2_clk_oe ? 1'b0 : dev_clk;
    wire  ps2_data_pin = (ps2_data_oe || dev_data_low) ? 1'b0 : 1'b1;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    ps2_host_tx_if txi();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (STO),
        .PACKET_TIMEOUT (PTO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx          (txi),
        .ps2_clk_in  (ps2_clk_pin),
        .ps2_data_in (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   clk_oe_cnt = 0;
    int   both_oe_cnt = 0;
    int   rel_cyc = 0;
    logic prev_clk_oe = 1'b0;

    // Per-cycle bus bookkeeping sampled on the inactive edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe === 1'b1) clk_oe_cnt <= clk_oe_cnt + 1;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) both_oe_cnt <= both_oe_cnt + 1;
        if (prev_clk_oe === 1'b1 && ps2_clk_oe === 1'b0) rel_cyc <= cyc;
        prev_clk_oe <= ps2_clk_oe;
    end

    function automatic logic [10:0] frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    task automatic send(input logic [7:0] d);
        txi.tx_data  = d;
        txi.tx_valid = 1'b1;
        @(negedge clk);
        txi.tx_valid = 1'b0;
    endtask

    // Keyboard model: waits for request-to-send, then clocks 'falls' edges.
    task automatic device_frame(input int falls, input bit ack, input bit glitch,
                                output logic [10:0] bits, output bit ok);
        int t;
        bits = 11'h000;
        ok   = 1'b0;
        t    = 0;
        dev_data_low = 1'b0;
        while (!(ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) return;
        if (glitch) begin
            repeat (20) @(negedge clk);
            dev_clk = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b1;
            repeat (28) @(negedge clk);
        end else begin
            repeat (50) @(negedge clk);
        end
        bits[0] = ps2_data_pin;
        for (int k = 1; k <= falls; k++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            if (k == falls && falls < 11) begin
                ok = 1'b1;
                return;
            end
            dev_clk = 1'b1;
            if (k == 11) begin
                dev_data_low = 1'b0;
                break;
            end
            bits[k] = ps2_data_pin;
            if (glitch) begin
                repeat (5) @(negedge clk);
                dev_clk = 1'b0;
                repeat (2) @(negedge clk);
                dev_clk = 1'b1;
                repeat (3) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            if (k == 10 && ack) dev_data_low = 1'b1;
            repeat (10) @(negedge clk);
        end
        ok = 1'b1;
    endtask

    // Bounded wait for the status pulse; captures the bus state at that cycle.
    task automatic wait_done(input int bound, output bit seen, output logic [1:0] err,
                             output logic coe, output logic doe, output int dcyc);
        seen = 1'b0;
        err  = 2'bxx;
        coe  = 1'bx;
        doe  = 1'bx;
        dcyc = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (txi.tx_done === 1'b1) begin
                seen = 1'b1;
                err  = txi.tx_err;
                coe  = ps2_clk_oe;
                doe  = ps2_data_oe;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (txi.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", txi.tx_ready); end
        total++; if (txi.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", txi.busy); end
        total++; if (txi.tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b want=0", txi.tx_done); end
        total++; if (txi.tx_err !== 2'd0) begin bad++; $display("FAIL reset_tx_err got=%0d want=0", txi.tx_err); end
        total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            bad++; $display("FAIL reset_oe got=%b%b want=00", ps2_clk_oe, ps2_data_oe);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_send_ed();
        int c0, b0, dc;
        bit seen, ok;
        logic [1:0] err;
        logic coe, doe;
        logic [10:0] got;
        exp_t e;
        c0 = clk_oe_cnt;
        b0 = both_oe_cnt;
        exp_q.push_back('{bits: frame(CMD_SET_LED), err: ERR_OK, chk_bits: 1'b1});
        send(CMD_SET_LED);
        fork
            device_frame(11, 1'b1, 1'b0, got, ok);
            wait_done(3000, seen, err, coe, doe, dc);
        join
        e = exp_q.pop_front();
        total++; if (!seen) begin bad++; $display("FAIL ed_done got=none want=pulse"); end
        total++; if (!ok) begin bad++; $display("FAIL ed_rts got=no request want=request"); end
        total++; if (err !== e.err) begin bad++; $display("FAIL ed_err got=%0d want=%0d", err, e.err); end
        total++; if (got !== e.bits) begin bad++; $display("FAIL ed_bits got=%b want=%b", got, e.bits); end
        total++; if (got !== 11'b11111011010) begin bad++; $display("FAIL ed_bits_const got=%b want=11111011010", got); end
        total++; if (clk_oe_cnt - c0 != INH) begin bad++; $display("FAIL ed_inhibit_len got=%0d want=%0d", clk_oe_cnt - c0, INH); end
        total++; if (both_oe_cnt - b0 != 1) begin bad++; $display("FAIL ed_start_len got=%0d want=1", both_oe_cnt - b0); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_send_f4();
        int dc;
        bit seen, ok;
        logic [1:0] err;
        logic coe, doe;
        logic [10:0] got;
        exp_t e;
        exp_q.push_back('{bits: frame(CMD_ENABLE), err: ERR_OK, chk_bits: 1'b1});
        send(CMD_ENABLE);
        fork
            device_frame(11, 1'b1, 1'b0, got, ok);
            wait_done(3000, seen, err, coe, doe, dc);
        join
        e = exp_q.pop_front();
        total++; if (!seen || err !== e.err) begin bad++; $display("FAIL f4_err seen=%0d got=%0d want=%0d", seen, err, e.err); end
        total++; if (got !== e.bits) begin bad++; $display("FAIL f4_bits got=%b want=%b", got, e.bits); end
        total++; if (got[9] !== 1'b0) begin bad++; $display("FAIL f4_parity got=%b want=0", got[9]); end
        total++; if (txi.tx_ready !== 1'b0) begin bad++; $display("FAIL f4_ready_at_done got=%b want=0", txi.tx_ready); end
        @(negedge clk);
        total++; if (txi.tx_ready !== 1'b1) begin bad++; $display("FAIL f4_ready_after got=%b want=1", txi.tx_ready); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_no_ack();
        int dc;
        bit seen, ok;
        logic [1:0] err;
        logic coe, doe;
        logic [10:0] got;
        exp_t e;
        exp_q.push_back('{bits: frame(CMD_ENABLE), err: ERR_NOACK, chk_bits: 1'b1});
        send(CMD_ENABLE);
        fork
            device_frame(11, 1'b0, 1'b0, got, ok);
            wait_done(3000, seen, err, coe, doe, dc);
        join
        e = exp_q.pop_front();
        total++; if (!seen || err !== e.err) begin bad++; $display("FAIL noack_err seen=%0d got=%0d want=%0d", seen, err, e.err); end
        total++; if (coe !== 1'b0 || doe !== 1'b0) begin bad++; $display("FAIL noack_oe got=%b%b want=00", coe, doe); end
        total++; if (got !== e.bits) begin bad++; $display("FAIL noack_bits got=%b want=%b", got, e.bits); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_start_timeout();
        int dc;
        bit seen;
        logic [1:0] err;
        logic coe, doe;
        exp_t e;
        exp_q.push_back('{bits: 11'h000, err: ERR_TIMEOUT, chk_bits: 1'b0});
        send(CMD_RESET);
        wait_done(2000, seen, err, coe, doe, dc);
        e = exp_q.pop_front();
        total++; if (!seen || err !== e.err) begin bad++; $display("FAIL timeout_err seen=%0d got=%0d want=%0d", seen, err, e.err); end
        total++; if (dc - rel_cyc != STO) begin bad++; $display("FAIL timeout_delay got=%0d want=%0d", dc - rel_cyc, STO); end
        total++; if (coe !== 1'b0 || doe !== 1'b0) begin bad++; $display("FAIL timeout_oe got=%b%b want=00", coe, doe); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dc;
        bit seen, ok;
        logic [1:0] err;
        logic coe, doe;
        logic [10:0] got;
        exp_t e;
        send(8'h00);
        device_frame(5, 1'b1, 1'b0, got, ok);
        total++; if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL mid_data_oe got=%b want=1", ps2_data_oe); end
        #2 rst = 1'b0;
        #1;
        total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            bad++; $display("FAIL mid_async_oe got=%b%b want=00", ps2_clk_oe, ps2_data_oe);
        end
        total++; if (txi.tx_ready !== 1'b1 || txi.busy !== 1'b0) begin
            bad++; $display("FAIL mid_async_ready got=%b/%b want=1/0", txi.tx_ready, txi.busy);
        end
        dev_clk = 1'b1;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back('{bits: frame(CMD_RESET), err: ERR_OK, chk_bits: 1'b1});
        send(CMD_RESET);
        fork
            device_frame(11, 1'b1, 1'b0, got, ok);
            wait_done(3000, seen, err, coe, doe, dc);
        join
        e = exp_q.pop_front();
        total++; if (!seen || err !== e.err) begin bad++; $display("FAIL ff_err seen=%0d got=%0d want=%0d", seen, err, e.err); end
        total++; if (got !== e.bits) begin bad++; $display("FAIL ff_bits got=%b want=%b", got, e.bits); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dc;
        bit seen, ok;
        logic [1:0] err;
        logic coe, doe;
        logic [10:0] got;
        exp_t e;
        exp_q.push_back('{bits: frame(CMD_ENABLE), err: ERR_OK, chk_bits: 1'b1});
        exp_q.push_back('{bits: frame(CMD_SET_LED), err: ERR_OK, chk_bits: 1'b1});
        txi.tx_data  = CMD_ENABLE;
        txi.tx_valid = 1'b1;
        @(negedge clk);
        txi.tx_data = CMD_SET_LED;
        fork
            device_frame(11, 1'b1, 1'b1, got, ok);
            wait_done(3000, seen, err, coe, doe, dc);
        join
        e = exp_q.pop_front();
        total++; if (!seen || err !== e.err) begin bad++; $display("FAIL b2b_first_err seen=%0d got=%0d want=%0d", seen, err, e.err); end
        total++; if (got !== e.bits) begin bad++; $display("FAIL b2b_first_bits got=%b want=%b", got, e.bits); end
        @(negedge clk);
        total++; if (txi.busy !== 1'b0 || txi.tx_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_idle_gap got=%b/%b want=0/1", txi.busy, txi.tx_ready);
        end
        @(negedge clk);
        total++; if (txi.busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept got=%b want=1", txi.busy); end
        txi.tx_valid = 1'b0;
        fork
            device_frame(11, 1'b1, 1'b1, got, ok);
            wait_done(3000, seen, err, coe, doe, dc);
        join
        e = exp_q.pop_front();
        total++; if (!seen || err !== e.err) begin bad++; $display("FAIL b2b_second_err seen=%0d got=%0d want=%0d", seen, err, e.err); end
        total++; if (got !== e.bits) begin bad++; $display("FAIL b2b_second_bits got=%b want=%b", got, e.bits); end
        repeat (5) @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        txi.tx_data  = 8'h00;
        txi.tx_valid = 1'b0;
        test_reset();
        test_send_ed();
        test_send_f4();
        test_no_ack();
        test_start_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It is the outbound counterpart of the keyboard decoder and shares the PS2_CLK/PS2_DATA open-drain pins with it. It performs the full request-to-send sequence, shifts out 8N1 data with odd parity, checks the device ACK and reports status to the game FSM.

Parameters:
INHIBIT_CYCLES, 10000, cycles CLK is held low before requesting to send (100 us at 100 MHz)
START_TIMEOUT, 1500000, maximum cycles from CLK release to the first device falling edge (15 ms)
PACKET_TIMEOUT, 200000, maximum cycles from the first falling edge to the ACK edge (2 ms)
FILTER_LEN, 4, consecutive equal synchronized samples required to accept a new PS2_CLK level

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
tx_data  in  8  command byte
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  idle and able to accept a byte
busy  out  1  transfer in progress; the decoder ignores bus traffic while high
tx_done  out  1  one-cycle pulse at the end of a transfer
tx_err  out  2  valid with tx_done: 0 = OK, 1 = no ACK, 2 = timeout
ps2_clk_in  in  1  raw PS2_CLK pin level
ps2_data_in  in  1  raw PS2_DATA pin level
ps2_clk_oe  out  1  1 = pull PS2_CLK low (top level: PS2_CLK = oe ? 0 : z)
ps2_data_oe  out  1  1 = pull PS2_DATA low

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, tx_ready=1, busy=0, tx_done=0, tx_err=0, both oe=0. The bus is released immediately, including mid-frame. Filter state is set to "high".
- Input conditioning: 2-flop synchronizer on both pins. The clock filter accepts a new level only after FILTER_LEN identical samples. fall = one-cycle pulse when the filtered clock goes 1->0. Total latency from pin edge to fall is 2+FILTER_LEN cycles.
- Accept: in IDLE with tx_valid=1, latch tx_data and parity = ~^tx_data, then go to INHIBIT. tx_ready=0 and busy=1 from the next cycle.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES-1 cycles, then clk_oe=1 and data_oe=1 for 1 cycle (start bit), then go to RELEASE.
- RELEASE: clk_oe=0, data_oe=1. Wait for fall.
  - If START_TIMEOUT cycles pass with no fall, go to ERR with code 2.
- SHIFT: edge counter n counts fall pulses from 1; PACKET_TIMEOUT counter starts at the first fall.
  - Falls 1..8: drive data bit n-1 (LSB first); data_oe = ~bit.
  - Fall 9: data_oe = ~parity.
  - Fall 10: data_oe=0 (stop bit, line released).
  - Fall 11: sample synchronized data. 0 = ACK, go to WAIT_IDLE. 1 = go to ERR with code 1.
  - Each data change takes effect on the cycle after fall.
  - PACKET_TIMEOUT expiring before fall 11 goes to ERR with code 2.
- WAIT_IDLE: wait until filtered clk=1 and synchronized data=1, then go to DONE. Waiting past PACKET_TIMEOUT (counter continues) goes to ERR with code 2.
- DONE/ERR: one cycle with tx_done=1, tx_err set, both oe=0, busy=1. Next state is IDLE.
- Boundary conditions:
  - tx_valid while busy: ignored, no queue.
  - tx_valid in the DONE cycle: ignored; accepted only from IDLE.
  - Device clock edges during IDLE: ignored.
  - Glitches shorter than FILTER_LEN cycles on PS2_CLK: not counted.
  - Counters saturate; no wrap-around.

Decomposition:
- Shared package ps2_pkg:
  - state encoding (IDLE, INHIBIT, RELEASE, SHIFT, WAIT_IDLE, DONE, ERR)
  - error codes ERR_OK/ERR_NOACK/ERR_TIMEOUT
  - frame constants (DATA_BITS=8, ACK_EDGE=11)
  - PS/2 command bytes (CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF)
- Sub-module ps2_line_sync: 2-flop sync + FILTER_LEN deglitch + falling-edge pulse. It is instantiated for PS2_CLK (data uses its synchronized output only). The decoder can reuse it.

Test Plan:
- All tests use INHIBIT_CYCLES=20 and FILTER_LEN=4. A device model clocks at a 40-cycle period and pulls data low before fall 11.
- Send 0xED -> clk_oe high for exactly 19+1 cycles. Bits seen at device rising edges: 0(start),1,0,1,1,0,1,1,1,1(parity),1(stop). tx_done with tx_err=0.
- Send 0xF4 -> parity bit 0; bits 0,0,1,0,1,1,1,1 after the start bit; tx_err=0. tx_ready returns 1 the cycle after tx_done.
- Device omits ACK (data high at fall 11) -> tx_done with tx_err=1; both oe=0.
- Device never clocks; START_TIMEOUT=500 -> tx_done with tx_err=2 exactly 500 cycles after RELEASE entry. Bus released.
- Reset asserted at fall 5 -> clk_oe=data_oe=0 in the same cycle (asynchronous), tx_ready=1. A new 0xFF sent after reset completes with tx_err=0.
- Back-to-back tx_valid held high throughout, plus 2-cycle glitches on PS2_CLK -> second byte accepted only from IDLE. Glitches produce no extra bit shifts.
